// File: rtl/clock_monitor.sv
// Clock-under-test monitor: counts synchronized MON_IN rising edges per window and flags
// out-of-range frequency and stuck clocks. Define CLOCK_MONITOR_DUTY_EN to add a duty-cycle check.
module clock_monitor #(
  parameter int unsigned WINDOW      = 100,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MIN_EDGES   = 20,
  parameter int unsigned MAX_EDGES   = 30,
  parameter int unsigned STUCK_LIMIT = 64
`ifdef CLOCK_MONITOR_DUTY_EN
  ,
  parameter int unsigned DUTY_MIN_PCT = 40,
  parameter int unsigned DUTY_MAX_PCT = 60
`endif
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             MON_IN,
  input  logic             CLR_FAULT,
  output logic [CNT_W-1:0] EDGE_COUNT,
  output logic             COUNT_VALID,
  output logic             FREQ_OK,
  output logic             FAULT,
  output logic             STUCK
`ifdef CLOCK_MONITOR_DUTY_EN
  ,
  output logic [CNT_W-1:0] HIGH_COUNT
`endif
);

  localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned STK_W = $clog2(STUCK_LIMIT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_REPORT  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_q, s2_q, s3_q;
  logic             rise_c, any_edge_c;
  logic [1:0]       state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] edge_q, edge_d, edge_final_c;
  logic [CNT_W-1:0] edge_count_q, edge_count_d;
  logic             count_valid_q, count_valid_d;
  logic             freq_ok_q, freq_ok_d;
  logic             fault_q, fault_d;
  logic [STK_W-1:0] stk_q, stk_d;
  logic             stuck_q, stuck_d;
  logic             win_last_c, report_c, in_range_c, window_ok_c, report_fail_c;

  // Two-flop synchronizer plus one flop of history for edge detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= MON_IN;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_c     = s2_q & ~s3_q;
  assign any_edge_c = s2_q ^ s3_q;

  // Edge count including this cycle's rise, saturating
  always_comb begin
    edge_final_c = edge_q;
    if (rise_c && (edge_q != CNT_MAX)) begin
      edge_final_c = edge_q + 1'b1;
    end
  end

  assign win_last_c = (win_q == WIN_W'(WINDOW - 1));
  assign report_c   = (state_q == S_MEASURE) && EN && win_last_c;
  assign in_range_c = (edge_final_c >= CNT_W'(MIN_EDGES)) && (edge_final_c <= CNT_W'(MAX_EDGES));

`ifdef CLOCK_MONITOR_DUTY_EN
  localparam int unsigned DW = CNT_W + 7;
  localparam logic [DW-1:0] DUTY_LO = DW'(DUTY_MIN_PCT * WINDOW);
  localparam logic [DW-1:0] DUTY_HI = DW'(DUTY_MAX_PCT * WINDOW);

  logic [CNT_W-1:0] high_q, high_d, high_final_c;
  logic [CNT_W-1:0] high_count_q, high_count_d;
  logic [DW-1:0]    high_scaled_c;
  logic             duty_ok_c;

  always_comb begin
    high_final_c = high_q;
    if (s2_q && (high_q != CNT_MAX)) begin
      high_final_c = high_q + 1'b1;
    end
  end

  // Percent comparison done wide enough that count*100 never overflows
  assign high_scaled_c = DW'(high_final_c) * DW'(100);
  assign duty_ok_c     = (high_scaled_c >= DUTY_LO) && (high_scaled_c <= DUTY_HI);
  assign window_ok_c   = in_range_c & duty_ok_c;

  always_comb begin
    high_d       = '0;
    high_count_d = high_count_q;
    if ((state_q == S_MEASURE) && EN) begin
      if (win_last_c) begin
        high_count_d = high_final_c;
      end else begin
        high_d = high_final_c;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      high_q       <= '0;
      high_count_q <= '0;
    end else begin
      high_q       <= high_d;
      high_count_q <= high_count_d;
    end
  end

  assign HIGH_COUNT = high_count_q;
`else
  assign window_ok_c = in_range_c;
`endif

  // Window FSM; report registers load on the last MEASURE cycle so they are visible during REPORT
  always_comb begin
    state_d       = state_q;
    win_d         = '0;
    edge_d        = '0;
    edge_count_d  = edge_count_q;
    count_valid_d = 1'b0;
    freq_ok_d     = freq_ok_q;
    report_fail_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (EN) begin
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (!EN) begin
          state_d = S_IDLE;
        end else if (report_c) begin
          state_d       = S_REPORT;
          edge_count_d  = edge_final_c;
          count_valid_d = 1'b1;
          freq_ok_d     = window_ok_c;
          report_fail_c = ~window_ok_c;
        end else begin
          win_d  = win_q + 1'b1;
          edge_d = edge_final_c;
        end
      end
      S_REPORT: begin
        state_d = EN ? S_MEASURE : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Stuck detector runs independently of the window FSM
  always_comb begin
    stk_d = stk_q;
    if (!EN || any_edge_c) begin
      stk_d = '0;
    end else if (stk_q != STK_W'(STUCK_LIMIT)) begin
      stk_d = stk_q + 1'b1;
    end
    stuck_d = (stk_d == STK_W'(STUCK_LIMIT));
  end

  // Sticky fault: a set condition wins over a simultaneous clear
  always_comb begin
    fault_d = fault_q;
    if (report_fail_c || stuck_q) begin
      fault_d = 1'b1;
    end else if (CLR_FAULT) begin
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_IDLE;
      win_q         <= '0;
      edge_q        <= '0;
      edge_count_q  <= '0;
      count_valid_q <= 1'b0;
      freq_ok_q     <= 1'b0;
      fault_q       <= 1'b0;
      stk_q         <= '0;
      stuck_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      edge_q        <= edge_d;
      edge_count_q  <= edge_count_d;
      count_valid_q <= count_valid_d;
      freq_ok_q     <= freq_ok_d;
      fault_q       <= fault_d;
      stk_q         <= stk_d;
      stuck_q       <= stuck_d;
    end
  end

  assign EDGE_COUNT  = edge_count_q;
  assign COUNT_VALID = count_valid_q;
  assign FREQ_OK     = freq_ok_q;
  assign FAULT       = fault_q;
  assign STUCK       = stuck_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Randomized bench for clock_monitor: per-phase stimulus tables, a window-level reference
// model feeding a report scoreboard, and a monitor checking every cycle.
module tb_clock_monitor;

  localparam int WINDOW      = 100;
  localparam int CNT_W       = 16;
  localparam int MIN_EDGES   = 20;
  localparam int MAX_EDGES   = 30;
  localparam int STUCK_LIMIT = 64;
`ifdef CLOCK_MONITOR_DUTY_EN
  localparam int DUTY_MIN_PCT = 40;
  localparam int DUTY_MAX_PCT = 60;
`endif
  localparam int NMAX   = 2000;
  localparam int NPHASE = 3;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b1;
  logic             en        = 1'b0;
  logic             mon_in    = 1'b0;
  logic             clr_fault = 1'b0;
  logic [CNT_W-1:0] edge_count;
  logic             count_valid;
  logic             freq_ok;
  logic             fault;
  logic             stuck;
`ifdef CLOCK_MONITOR_DUTY_EN
  logic [CNT_W-1:0] high_count;
`endif

  clock_monitor #(
    .WINDOW(WINDOW), .CNT_W(CNT_W), .MIN_EDGES(MIN_EDGES),
    .MAX_EDGES(MAX_EDGES), .STUCK_LIMIT(STUCK_LIMIT)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .MON_IN(mon_in), .CLR_FAULT(clr_fault),
    .EDGE_COUNT(edge_count), .COUNT_VALID(count_valid), .FREQ_OK(freq_ok),
    .FAULT(fault), .STUCK(stuck)
`ifdef CLOCK_MONITOR_DUTY_EN
    , .HIGH_COUNT(high_count)
`endif
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    int cyc;
    int cnt;
    bit ok;
    int high;
  } rep_t;

  rep_t sb_q[$];
  bit   en_a[NMAX];
  bit   mon_a[NMAX];
  bit   clr_a[NMAX];
  bit   fail_a[NMAX];
  bit   stuck_a[NMAX];
  bit   fault_a[NMAX];

  int total = 0;
  int bad   = 0;
  int cur   = 0;
  bit active = 1'b0;
  int last_cnt  = 0;
  int last_ok   = 0;
  int last_high = 0;

  task automatic check(input string name, input int idx, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, idx, act, exp);
    end
  endtask

  function automatic bit m_at(input int i);
    return (i < 0) ? 1'b0 : mon_a[i];
  endfunction

  task automatic check_reset(input int idx);
    check("rst_edge_count", idx, edge_count, 0);
    check("rst_count_valid", idx, count_valid, 0);
    check("rst_freq_ok", idx, freq_ok, 0);
    check("rst_fault", idx, fault, 0);
    check("rst_stuck", idx, stuck, 0);
`ifdef CLOCK_MONITOR_DUTY_EN
    check("rst_high_count", idx, high_count, 0);
`endif
  endtask

  // Random segments: nominal, fast, odd periods/duties, noise, stuck level, EN drops
  task automatic gen_phase(input int n);
    int j, len, sel, p, h, off;
    bit e, lvl;
    j = 0;
    for (int i = 0; i < n; i++) fail_a[i] = 1'b0;
    while (j < n) begin
      sel = (j == 0) ? 0 : int'($urandom_range(0, 9));
      len = int'($urandom_range(50, 400));
      e   = 1'b1;
      p   = 4;
      h   = 2;
      off = int'($urandom_range(0, 3));
      lvl = 1'($urandom_range(0, 1));
      case (sel)
        3: begin p = 2; h = 1; off = int'($urandom_range(0, 1)); end
        4: begin
          p   = int'($urandom_range(3, 6));
          h   = int'($urandom_range(1, p - 1));
          off = int'($urandom_range(0, p - 1));
        end
        7: len = int'($urandom_range(70, 200));
        8: begin e = 1'b0; len = int'($urandom_range(1, 60)); end
        9: begin e = 1'b0; len = int'($urandom_range(1, 3)); end
        default: ;
      endcase
      if (j == 0) len = 350;
      for (int t = 0; t < len && j < n; t++) begin
        en_a[j] = e;
        case (sel)
          5, 6, 8, 9: mon_a[j] = 1'($urandom_range(0, 1));
          7:          mon_a[j] = lvl;
          default:    mon_a[j] = (((j + off) % p) < h);
        endcase
        clr_a[j] = ($urandom_range(0, 39) == 0);
        j++;
      end
    end
    for (int i = n - 300; i < n; i++) en_a[i] = 1'b1;
  endtask

  // Reference: every EN run of length L starting at cycle k yields windows ending at
  // k+WINDOW+n*(WINDOW+1) that fit inside the run; a rise reaches the counter two cycles late.
  task automatic compute_model(input int n);
    int  l, cnt, high, q;
    bit  ok, f, prev_stuck;
    sb_q.delete();
    for (int k = 0; k < n; k++) begin
      if (en_a[k] && (k == 0 || !en_a[k-1])) begin
        l = 0;
        while (k + l < n && en_a[k+l]) l++;
        for (int e = k + WINDOW; e <= k + l - 1; e += WINDOW + 1) begin
          cnt  = 0;
          high = 0;
          for (int i = e - WINDOW + 1; i <= e; i++) begin
            if (m_at(i - 2) && !m_at(i - 3)) cnt++;
            if (m_at(i - 2)) high++;
          end
          ok = (cnt >= MIN_EDGES) && (cnt <= MAX_EDGES);
`ifdef CLOCK_MONITOR_DUTY_EN
          ok = ok && (high * 100 >= DUTY_MIN_PCT * WINDOW) && (high * 100 <= DUTY_MAX_PCT * WINDOW);
`endif
          sb_q.push_back('{cyc: e, cnt: cnt, ok: ok, high: high});
          fail_a[e] = !ok;
        end
      end
    end
    q = 0;
    for (int j = 0; j < n; j++) begin
      if (en_a[j] && (m_at(j - 2) == m_at(j - 3))) q = (q < STUCK_LIMIT) ? q + 1 : q;
      else q = 0;
      stuck_a[j] = (q >= STUCK_LIMIT);
    end
    f = 1'b0;
    for (int j = 0; j < n; j++) begin
      prev_stuck = (j > 0) ? stuck_a[j-1] : 1'b0;
      if (fail_a[j] || prev_stuck) f = 1'b1;
      else if (clr_a[j]) f = 1'b0;
      fault_a[j] = f;
    end
  endtask

  task automatic run_phase(input int n);
    gen_phase(n);
    compute_model(n);
    last_cnt  = 0;
    last_ok   = 0;
    last_high = 0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      cur       = j;
      en        = en_a[j];
      mon_in    = mon_a[j];
      clr_fault = clr_a[j];
      active    = 1'b1;
    end
    @(posedge clk);
    #3;
    active = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset(n);
    check("sb_drain", n, sb_q.size(), 0);
    en        = 1'b0;
    mon_in    = 1'b0;
    clr_fault = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Monitor: the scoreboard front names the cycle of the next expected report
  task automatic check_cycle(input int idx);
    rep_t r;
    bit   exp_v;
    exp_v = (sb_q.size() > 0) && (sb_q[0].cyc == idx);
    check("count_valid", idx, count_valid, exp_v);
    if (exp_v) begin
      r = sb_q.pop_front();
      check("edge_count", idx, edge_count, r.cnt);
      check("freq_ok", idx, freq_ok, r.ok);
`ifdef CLOCK_MONITOR_DUTY_EN
      check("high_count", idx, high_count, r.high);
`endif
      last_cnt  = r.cnt;
      last_ok   = r.ok;
      last_high = r.high;
    end else begin
      check("edge_count_hold", idx, edge_count, last_cnt);
      check("freq_ok_hold", idx, freq_ok, last_ok);
`ifdef CLOCK_MONITOR_DUTY_EN
      check("high_count_hold", idx, high_count, last_high);
`endif
    end
    check("stuck", idx, stuck, stuck_a[idx]);
    check("fault", idx, fault, fault_a[idx]);
  endtask

  initial begin
    int idx;
    bit act;
    forever begin
      @(posedge clk);
      idx = cur;
      act = active;
      #1;
      if (act) check_cycle(idx);
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #1 check_reset(-1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int p = 0; p < NPHASE; p++) run_phase(NMAX);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
